noc_router_xy_buffered: RTL
===========================

// Module: noc_router_xy_buffered
// PURPOSE
//  Clocked 5-port 2D-mesh router (up/down/left/right/PE) with per-input FIFOs and round-robin output arbitration.
//  Single-flit packets are routed dimension-ordered: X first, then Y. Each router sits at one mesh node.
//  It links to neighbour routers and to its local PE through valid/ready channels.
//  Generalises the unbuffered switch+4-way-merge router: parametrised width, address size and buffer depth, plus fair arbitration.
// PARAMETERS
//  WIDTH      33    flit width in bits
//  AXW        2     destination-X field width
//  AYW        2     destination-Y field width
//  ADDR_X     0     this node's X coordinate (AXW bits)
//  ADDR_Y     0     this node's Y coordinate (AYW bits)
//  DEPTH      4     per-input FIFO depth in flits; power of two, >=2
//  CNT_W      16    statistics counter width (used only with ROUTER_STATS_EN)
// PORTS  (port index p: 0=up 1=down 2=left 3=right 4=pe; bus slice p = [p*WIDTH +: WIDTH])
//  clk        in   1         clock; all state updates on the rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_data    in   5*WIDTH   input flits
//  in_valid   in   5         input flit valid
//  in_ready   out  5         input may accept (FIFO not full)
//  out_data   out  5*WIDTH   output flits
//  out_valid  out  5         output flit valid
//  out_ready  in   5         downstream accepts
//  fwd_count  out  5*CNT_W   flits delivered per output (present only with ROUTER_STATS_EN)
// BEHAVIOUR
//  Flit fields:
//   - dest X = flit[WIDTH-1 -: AXW]; dest Y = flit[WIDTH-1-AXW -: AYW].
//   - All other bits pass through unmodified.
//  Route (computed on each FIFO head, unsigned compares):
//   - X>ADDR_X -> right; X<ADDR_X -> left.
//   - else Y>ADDR_Y -> up; Y<ADDR_Y -> down.
//   - else -> pe.
//   - A U-turn (route equals the arrival port) is legal and is forwarded.
//  Input side:
//   - Transfer happens when in_valid&in_ready at a clock edge; the flit is pushed into FIFO[p].
//   - in_ready[p] = !full[p]. It is a registered-state function with no combinational path from in_valid or out_ready.
//   - A full FIFO never accepts; there is no same-cycle bypass.
//   - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
//  Arbitration (one independent arbiter per output o):
//   - Requesters are the non-empty FIFOs whose head routes to o.
//   - Round-robin pointer rr[o] resets to 0. Search starts at rr[o] and goes upward, modulo 5.
//   - On a grant to input i, rr[o] <= (i+1)%5.
//   - Each FIFO head requests exactly one output, so an input is granted at most once per cycle.
//  Output stage: one register per output.
//   - It loads the granted flit when out_valid[o]==0 or out_ready[o]==1 in that cycle (full-throughput pipelining).
//   - The loading grant pops the head of the source FIFO.
//  Output hold rule:
//   - While out_valid[o]&!out_ready[o], out_data[o] is stable and no grant is issued for o.
//  Latency and throughput:
//   - Minimum 2 edges from input transfer to out_valid, with an idle router and out_ready=1.
//   - Throughput is 1 flit/cycle/output.
//  Ordering: flits from the same input to the same output leave in arrival order.
//  Reset (async assert, sync release):
//   - FIFOs are emptied and rr=0; out_valid=0, out_data=0, in_ready=5'b11111, fwd_count=0.
//   - Reset asserted mid-transfer discards every buffered flit; no partial state survives.
// CONFIGURATION
//  ROUTER_STATS_EN defined:
//   - fwd_count port exists. Counter o increments on each out_valid[o]&out_ready[o] handshake.
//   - The counter saturates at 2**CNT_W-1 and does not wrap.
//   - Counters are reset only by rst_n.
//  ROUTER_STATS_EN undefined:
//   - No fwd_count port and no counter logic.
//   - Datapath behaviour is identical in both builds.
// TESTING  (ADDR_X=1, ADDR_Y=1, AXW=AYW=2, DEPTH=4)
//  1. PE sends dest(X=3,Y=0) -> appears on right after 2 edges; dest(1,1) from left -> pe; dest(1,3) -> up; (1,0) -> down; (0,2) -> left.
//  2. up, left and pe all send to dest(1,1) every cycle with out_ready[pe]=1 -> grants rotate 0,2,4,0,2,4; each input gets 1/3 of cycles.
//  3. out_ready[right]=0 while left streams dest(3,1) -> left accepts exactly 4+1 flits, then in_ready[left]=0; out_data held stable; releasing delivers the flits in order.
//  4. Head-of-line: left FIFO head is blocked toward right while up sends to pe -> up traffic flows unaffected at 1 flit/cycle.
//  5. Assert rst_n low with 3 flits buffered and out_valid=1 -> outputs go 0 immediately; after release no stale flit ever appears.
//  6. ROUTER_STATS_EN, CNT_W=4: send 20 flits to pe -> fwd_count[pe] saturates at 15; other counters stay 0.

Source files
------------

// File: rtl/noc_router_xy_buffered.sv
// 5-port XY mesh router: per-input FIFOs, round-robin per-output arbitration, registered outputs.
// Optional per-output delivered-flit counters when ROUTER_STATS_EN is defined.
module noc_router_xy_buffered #(
    parameter int WIDTH  = 33,
    parameter int AXW    = 2,
    parameter int AYW    = 2,
    parameter int ADDR_X = 0,
    parameter int ADDR_Y = 0,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5*WIDTH-1:0] in_data,
    input  logic [4:0]         in_valid,
    output logic [4:0]         in_ready,
    output logic [5*WIDTH-1:0] out_data,
    output logic [4:0]         out_valid,
    input  logic [4:0]         out_ready
`ifdef ROUTER_STATS_EN
    ,
    output logic [5*CNT_W-1:0] fwd_count
`endif
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [AXW-1:0] MY_X    = AXW'(ADDR_X);
    localparam logic [AYW-1:0] MY_Y    = AYW'(ADDR_Y);

    logic [5*WIDTH-1:0] head_flat;
    logic [14:0]        route_flat;
    logic [4:0]         push;
    logic [4:0]         pop;
    logic [4:0]         empty;
    logic [4:0]         gnt_valid;
    logic [14:0]        gnt_idx_flat;
    logic [4:0]         can_load;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_in
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wr_ptr_q;
            logic [PW-1:0]    rd_ptr_q;
            logic [PW:0]      count_q;
            logic [PW:0]      count_d;
            logic [WIDTH-1:0] head;
            logic [AXW-1:0]   dx;
            logic [AYW-1:0]   dy;
            logic [2:0]       route;

            assign push[gi]     = in_valid[gi] & in_ready[gi];
            assign in_ready[gi] = (count_q != FULL_CNT);
            assign empty[gi]    = (count_q == '0);
            assign head         = mem_q[rd_ptr_q];
            assign dx           = head[WIDTH-1 -: AXW];
            assign dy           = head[WIDTH-1-AXW -: AYW];
            assign head_flat[gi*WIDTH +: WIDTH] = head;
            assign route_flat[gi*3 +: 3]        = route;

            // X dimension resolved first, then Y; port codes 0=up 1=down 2=left 3=right 4=pe
            always_comb begin
                if (dx > MY_X)      route = 3'd3;
                else if (dx < MY_X) route = 3'd2;
                else if (dy > MY_Y) route = 3'd0;
                else if (dy < MY_Y) route = 3'd1;
                else                route = 3'd4;
            end

            always_comb begin
                count_d = count_q;
                if (push[gi] && !pop[gi])      count_d = count_q + 1'b1;
                else if (!push[gi] && pop[gi]) count_d = count_q - 1'b1;
            end

            always_ff @(posedge clk) begin
                if (push[gi]) mem_q[wr_ptr_q] <= in_data[gi*WIDTH +: WIDTH];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    count_q <= count_d;
                    if (push[gi]) wr_ptr_q <= wr_ptr_q + PW'(1);
                    if (pop[gi])  rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int o = 0; o < 5; o++) begin
            if (gnt_valid[o]) pop[gnt_idx_flat[o*3 +: 3]] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_out
            logic [2:0]       rr_q;
            logic [2:0]       rr_d;
            logic [4:0]       req;
            logic             gnt;
            logic [2:0]       gnt_idx;
            logic [3:0]       cand;
            logic             out_valid_q;
            logic [WIDTH-1:0] out_data_q;

            // A stalled output register blocks its own grants, which keeps out_data stable
            assign can_load[gi] = !out_valid_q || out_ready[gi];

            always_comb begin
                for (int i = 0; i < 5; i++) begin
                    req[i] = !empty[i] && (route_flat[i*3 +: 3] == 3'(gi));
                end
            end

            always_comb begin
                gnt     = 1'b0;
                gnt_idx = 3'd0;
                cand    = 4'd0;
                for (int k = 0; k < 5; k++) begin
                    cand = 4'(rr_q) + 4'(k);
                    if (cand >= 4'd5) cand = cand - 4'd5;
                    if (!gnt && req[cand[2:0]]) begin
                        gnt     = 1'b1;
                        gnt_idx = cand[2:0];
                    end
                end
                gnt = gnt & can_load[gi];
            end

            assign rr_d = (gnt_idx == 3'd4) ? 3'd0 : gnt_idx + 3'd1;
            assign gnt_valid[gi]             = gnt;
            assign gnt_idx_flat[gi*3 +: 3]   = gnt_idx;
            assign out_valid[gi]             = out_valid_q;
            assign out_data[gi*WIDTH +: WIDTH] = out_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_q        <= 3'd0;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else if (can_load[gi]) begin
                    out_valid_q <= gnt;
                    if (gnt) begin
                        out_data_q <= head_flat[gnt_idx*WIDTH +: WIDTH];
                        rr_q       <= rr_d;
                    end
                end
            end

`ifdef ROUTER_STATS_EN
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (out_valid_q && out_ready[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign fwd_count[gi*CNT_W +: CNT_W] = cnt_q;
`endif
        end
    endgenerate

endmodule
